inst_prefetch_queue: RTL
========================

INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, is the number of instruction queue entries; legal values are powers of two, 2..16.
REQ-002 clk  in  1  is the single clock; all state updates on the rising edge.
REQ-003 rst  in  1  is an asynchronous, active-low reset.
REQ-004 rom_ce  out  1  is the instruction ROM read enable.
REQ-005 rom_addr  out  32  is the ROM byte address, word-aligned.
REQ-006 rom_data  in  32  is the ROM read data, valid in the cycle after the cycle in which rom_ce=1 was presented.
REQ-007 redirect  in  1  is the branch/jump taken signal from decode.
REQ-008 redirect_pc  in  32  is the redirect target; bits [1:0] are ignored.
REQ-009 stall  in  1  means decode does not accept an instruction this cycle.
REQ-010 inst_valid  out  1  means the queue head holds a valid instruction.
REQ-011 inst  out  32  is the head instruction word.
REQ-012 inst_pc  out  32  is the head instruction byte address.

Function
REQ-013 The block SHALL hold fetch_pc, a count, read/write pointers modulo DEPTH, and an inflight bit set when rom_ce=1 in the previous cycle.
REQ-014 rom_addr SHALL equal {fetch_pc[31:2],2'b00} combinationally.
REQ-015 rom_ce SHALL equal ~redirect & (count + inflight < DEPTH), using registered values with no pop lookahead.
REQ-016 Each cycle with rom_ce=1, fetch_pc SHALL advance by 4 at the clock edge, wrapping 0xFFFFFFFC to 0x00000000.
REQ-017 When inflight=1 and redirect=0, {rom_data, previous rom_addr} SHALL be written at the tail at the clock edge.
REQ-018 Credit (REQ-015) SHALL guarantee that no write occurs when full; this SHALL be checked by assertion.
REQ-019 inst_valid SHALL equal (count != 0); inst and inst_pc SHALL show the head entry when valid and 0 when not valid (NOP bubble).
REQ-020 A pop SHALL occur when inst_valid=1, stall=0 and redirect=0.
REQ-021 A simultaneous write and pop SHALL leave count unchanged.
REQ-022 A redirect cycle SHALL, at the edge, empty the queue, reset the pointers, drop the response arriving that cycle, and load fetch_pc <= {redirect_pc[31:2],2'b00}.
REQ-023 Redirect SHALL take priority over write, pop and stall.
REQ-024 Latency: a request in cycle t SHALL appear at the head no earlier than cycle t+2.
REQ-025 Redirect latency: redirect in cycle r SHALL produce rom_ce=1 at the target in r+1 and inst_valid with inst_pc=target in r+3, provided stall=0.
REQ-026 Steady state with stall=0 SHALL deliver one instruction per cycle with contiguous inst_pc values.
REQ-027 Under stall, entries SHALL be held without loss or duplication, and fetch SHALL stop when count+inflight reaches DEPTH.

Reset
REQ-028 While rst=0: rom_ce=0, rom_addr=0, inst_valid=0, inst=0, inst_pc=0, fetch_pc=0, count=0, inflight=0, pointers=0.
REQ-029 Reset assertion mid-operation SHALL clear all state immediately, and any outstanding ROM response SHALL be discarded.
REQ-030 In the first cycle after rst rises, rom_ce SHALL be 1 with rom_addr=0x00000000.

Verification
REQ-031 Release reset, stall=0, ROM = 7 distinct words -> inst_valid first high in cycle 2 after release with inst_pc=0; then inst_pc=4,8,...,0x18 on consecutive cycles with matching words.
REQ-032 Hold stall=1 for 10 cycles mid-stream -> rom_ce drops once count+inflight=DEPTH and the head is held; release -> inst_pc sequence continues with no gap or repeat.
REQ-033 Redirect to 0x40 with 2 entries queued and 1 in flight -> no old entry emitted; next valid head has inst_pc=0x40, 3 cycles after the redirect cycle.
REQ-034 Redirect with redirect_pc=0x43 -> rom_addr=0x40 next cycle, and the head has inst_pc=0x40.
REQ-035 Drop rst mid-stream between edges -> all outputs 0 immediately; after release, fetch restarts at 0x00000000.
REQ-036 Redirect to 0xFFFFFFF8 -> inst_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.

Source files
------------

// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - instruction prefetch queue with credit-based ROM fetch
module inst_prefetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_prev_addr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic          r_inflight;
  logic [31:0]   r_mem_inst [DEPTH];
  logic [31:0]   r_mem_pc   [DEPTH];

  logic [CW-1:0] w_credit_used;
  logic          w_wr;
  logic          w_pop;

  // A request is only issued when a slot is reserved for its response.
  assign w_credit_used = r_count + CW'(r_inflight);
  assign rom_addr      = {r_fetch_pc[31:2], 2'b00};
  assign rom_ce        = rst & ~redirect & (w_credit_used < FULL);

  assign inst_valid = (r_count != '0);
  assign inst       = inst_valid ? r_mem_inst[r_rd_ptr] : '0;
  assign inst_pc    = inst_valid ? r_mem_pc[r_rd_ptr]   : '0;

  assign w_wr  = r_inflight & ~redirect;
  assign w_pop = inst_valid & ~stall & ~redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc  <= '0;
      r_prev_addr <= '0;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_inflight  <= 1'b0;
    end else if (redirect) begin
      // Flush everything, including the response landing this cycle.
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= rom_ce;
      if (rom_ce) begin
        r_fetch_pc  <= r_fetch_pc + 32'd4;
        r_prev_addr <= rom_addr;
      end
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_inst[r_wr_ptr] <= rom_data;
      r_mem_pc[r_wr_ptr]   <= r_prev_addr;
    end
  end

  a_no_write_when_full: assert property (
    @(posedge clk) disable iff (!rst) !(w_wr && r_count == FULL)
  );

endmodule
